mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the KCP53K cpu2 pipeline. Sits directly downstream of exec and consumes its registered outputs (rd, addr, we, nomem, mem, dat, xrs_rwe).
- Performs loads and stores over a 64-bit Wishbone-style master port. Passes ALU results through.
- Produces the register-file writeback and the busy_o stall that feeds exec's busy_i.

Parameters:
TIMEOUT, 255, cycles to wait for wb_ack_i before aborting (8-bit counter); 0 disables timeout.

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-high reset
rd_i  in  5  destination register from exec
addr_i  in  64  effective address (mem) or ALU result (nomem)
we_i  in  1  1 = store, 0 = load (meaningful only with mem_i)
nomem_i  in  1  ALU result writeback, no bus access
mem_i  in  1  memory access request
dat_i  in  64  store data (low bytes significant)
xrs_rwe_i  in  3  size/extension code: 000 none, 001 S8, 010 S16, 011 S32, 100 S64, 101 U8, 110 U16, 111 U32
busy_o  out  1  stall to exec; exec holds its outputs while high
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  bus strobe
wb_we_o  out  1  bus write
wb_adr_o  out  64  bus address, addr_i with [2:0] forced to 0
wb_sel_o  out  8  byte lane selects
wb_dat_o  out  64  store data, replicated across lanes
wb_dat_i  in  64  load data
wb_ack_i  in  1  bus acknowledge
rwe_o  out  1  register write enable
rd_o  out  5  writeback register
rdat_o  out  64  writeback data
fault_o  out  1  one-cycle pulse: misaligned access or bus timeout
fault_addr_o  out  64  address of the faulting access

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0. Reset asserted mid-bus-cycle drops cyc/stb immediately and discards the access with no writeback.
- FSM states:
  - IDLE: busy_o = 0; inputs sampled each edge.
  - BUS: cyc = stb = 1; busy_o = 1; inputs ignored.
- Bubble: nomem_i = mem_i = 0. Next cycle rwe_o = 0.
- nomem_i = 1 (mem_i ignored):
  - Next cycle rwe_o = (xrs_rwe_i != 0) and (rd_i != 0).
  - rd_o = rd_i; rdat_o = addr_i. One-cycle latency.
- mem_i = 1 in IDLE:
  - Size from xrs_rwe_i: 8/16/32/64 bits. Code 000 is treated as a bubble.
  - Alignment: misaligned if addr_i[0] and size ≥16, addr_i[1:0] ≠ 0 and size 32, or addr_i[2:0] ≠ 0 and size 64. Misaligned → next cycle fault_o = 1, fault_addr_o = addr_i, no bus cycle, rwe_o = 0; stay IDLE.
  - Aligned → next edge enters BUS with:
    - wb_adr_o = {addr_i[63:3], 3'b000}; wb_we_o = we_i.
    - wb_sel_o = size mask (0x01/0x03/0x0F/0xFF) shifted left by addr_i[2:0].
    - wb_dat_o = dat_i low byte/half/word replicated 8/4/2 times, or dat_i for 64-bit.
  - rd, size, extension and lane offset are latched.
- In BUS, each edge:
  - wb_ack_i = 1 → cyc/stb/we/sel drop next cycle and FSM returns to IDLE. Load: rwe_o = (rd ≠ 0) that same next cycle. rdat_o = selected lane of wb_dat_i, shifted right by offset×8, sign-extended (S codes) or zero-extended (U codes, S64). Store: rwe_o = 0.
  - No ack → counter increments. If TIMEOUT ≠ 0 and counter reaches TIMEOUT, abort: cyc/stb drop, fault_o pulses with latched address, no writeback, return to IDLE.
  - Counter clears on entry to BUS.
- Minimum load/store occupancy: one issue cycle plus BUS cycles until ack. busy_o is combinational from state only (no path from wb_ack_i). Exec therefore sees busy low in the same cycle that the writeback is presented.
- rwe_o and fault_o are single-cycle pulses. rd_o and rdat_o hold their last value when rwe_o = 0.
- Back-to-back: a new request sampled in the IDLE cycle after ack is legal; no dead cycle is required.

Test Plan:
1. nomem_i = 1, addr_i = 0x1234, rd_i = 5, xrs_rwe_i = S64 → next cycle rwe_o = 1, rd_o = 5, rdat_o = 0x1234, busy_o = 0, wb_cyc_o = 0. Repeat with rd_i = 0 → rwe_o = 0.
2. Load: mem_i = 1, we_i = 0, addr_i = 0xDFF802, xrs_rwe_i = S16, rd_i = 23; ack after 2 BUS cycles with wb_dat_i = 0x0000_0000_8001_0000.
   - BUS: wb_adr_o = 0xDFF800, wb_sel_o = 0x0C, busy_o = 1 for exactly 2 cycles.
   - Then rwe_o = 1, rd_o = 23, rdat_o = 0xFFFF_FFFF_FFFF_8001.
   - Same with U16 → rdat_o = 0x8001.
3. Store: mem_i = 1, we_i = 1, addr_i = 0xE007FF, dat_i = 0xDEAD, xrs_rwe_i = S8; immediate ack → wb_we_o = 1, wb_sel_o = 0x80, wb_dat_o = 0xADAD_ADAD_ADAD_ADAD, rwe_o stays 0, busy_o high 1 cycle.
4. Misaligned: S32 at addr_i = 0x3FF802 → next cycle fault_o = 1, fault_addr_o = 0x3FF802, wb_cyc_o never asserted, rwe_o = 0.
5. Timeout: TIMEOUT = 4, load with no ack → cyc high exactly 4 cycles, then fault_o pulse, no writeback. Then a nomem op completes normally.
6. Reset mid-BUS: assert reset_i asynchronously between edges → wb_cyc_o, wb_stb_o and busy_o fall without a clock edge. After release, no rwe_o pulse appears.

Source files
------------

// File: rtl/mem_stage_if.sv
// Pipeline-side and Wishbone-side signal bundle of the memory stage.
// The master view is mem_stage itself; the slave view is exec plus the bus target.
interface mem_stage_if;
  logic [4:0]  rd_i;
  logic [63:0] addr_i;
  logic        we_i;
  logic        nomem_i;
  logic        mem_i;
  logic [63:0] dat_i;
  logic [2:0]  xrs_rwe_i;
  logic        busy_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [63:0] wb_adr_o;
  logic [7:0]  wb_sel_o;
  logic [63:0] wb_dat_o;
  logic [63:0] wb_dat_i;
  logic        wb_ack_i;
  logic        rwe_o;
  logic [4:0]  rd_o;
  logic [63:0] rdat_o;
  logic        fault_o;
  logic [63:0] fault_addr_o;

  modport master (
    input  rd_i, addr_i, we_i, nomem_i, mem_i, dat_i, xrs_rwe_i, wb_dat_i, wb_ack_i,
    output busy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
           rwe_o, rd_o, rdat_o, fault_o, fault_addr_o
  );

  modport slave (
    output rd_i, addr_i, we_i, nomem_i, mem_i, dat_i, xrs_rwe_i, wb_dat_i, wb_ack_i,
    input  busy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
           rwe_o, rd_o, rdat_o, fault_o, fault_addr_o
  );
endinterface

// File: rtl/mem_stage.sv
// KCP53K cpu2 memory stage: ALU writeback pass-through plus loads/stores over a
// 64-bit Wishbone master with alignment checking and an optional ack timeout.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input logic         clk_i,
  input logic         reset_i,
  mem_stage_if.master bus
);
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_BUS      = 1'b1;
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  logic [0:0]  state_reg;
  logic [7:0]  count_reg;
  logic [4:0]  rd_lat_reg;
  logic [2:0]  code_lat_reg;
  logic [2:0]  off_lat_reg;
  logic [63:0] addr_lat_reg;
  logic        cyc_reg;
  logic        we_reg;
  logic [7:0]  sel_reg;
  logic [63:0] adr_reg;
  logic [63:0] wdat_reg;
  logic        rwe_reg;
  logic [4:0]  rd_reg;
  logic [63:0] rdat_reg;
  logic        fault_reg;
  logic [63:0] fault_addr_reg;

  logic [1:0]  lg_size;
  logic [7:0]  size_mask;
  logic [7:0]  sel_next;
  logic        misaligned;
  logic        issue_mem;
  logic        timeout_hit;
  logic [63:0] rep8;
  logic [63:0] rep16;
  logic [63:0] rep32;
  logic [63:0] wdat_next;
  logic [63:0] lane;
  logic [63:0] load_next;

  // log2 of the access size in bytes; code 000 never reaches here as an access
  always_comb begin
    case (bus.xrs_rwe_i)
      3'b001, 3'b101: lg_size = 2'd0;
      3'b010, 3'b110: lg_size = 2'd1;
      3'b011, 3'b111: lg_size = 2'd2;
      default:        lg_size = 2'd3;
    endcase
  end

  always_comb begin
    case (lg_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign sel_next   = size_mask << bus.addr_i[2:0];
  assign misaligned = ((lg_size != 2'd0) && bus.addr_i[0]) ||
                      (lg_size[1] && bus.addr_i[1]) ||
                      ((lg_size == 2'd3) && bus.addr_i[2]);
  assign issue_mem  = bus.mem_i && !bus.nomem_i && (bus.xrs_rwe_i != 3'b000);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rep
      assign rep8[gi*8 +: 8]  = bus.dat_i[7:0];
      assign rep16[gi*8 +: 8] = bus.dat_i[(gi % 2)*8 +: 8];
      assign rep32[gi*8 +: 8] = bus.dat_i[(gi % 4)*8 +: 8];
    end
  endgenerate

  always_comb begin
    case (lg_size)
      2'd0:    wdat_next = rep8;
      2'd1:    wdat_next = rep16;
      2'd2:    wdat_next = rep32;
      default: wdat_next = bus.dat_i;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend by the latched code.
  assign lane = bus.wb_dat_i >> {off_lat_reg, 3'b000};

  always_comb begin
    case (code_lat_reg)
      3'b001:  load_next = {{56{lane[7]}},  lane[7:0]};
      3'b010:  load_next = {{48{lane[15]}}, lane[15:0]};
      3'b011:  load_next = {{32{lane[31]}}, lane[31:0]};
      3'b101:  load_next = {56'd0, lane[7:0]};
      3'b110:  load_next = {48'd0, lane[15:0]};
      3'b111:  load_next = {32'd0, lane[31:0]};
      default: load_next = lane;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (({1'b0, count_reg} + 9'd1) == TIMEOUT_LIM);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg      <= ST_IDLE;
      count_reg      <= 8'd0;
      rd_lat_reg     <= 5'd0;
      code_lat_reg   <= 3'd0;
      off_lat_reg    <= 3'd0;
      addr_lat_reg   <= 64'd0;
      cyc_reg        <= 1'b0;
      we_reg         <= 1'b0;
      sel_reg        <= 8'd0;
      adr_reg        <= 64'd0;
      wdat_reg       <= 64'd0;
      rwe_reg        <= 1'b0;
      rd_reg         <= 5'd0;
      rdat_reg       <= 64'd0;
      fault_reg      <= 1'b0;
      fault_addr_reg <= 64'd0;
    end else begin
      rwe_reg   <= 1'b0;
      fault_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.nomem_i) begin
            if ((bus.xrs_rwe_i != 3'b000) && (bus.rd_i != 5'd0)) begin
              rwe_reg  <= 1'b1;
              rd_reg   <= bus.rd_i;
              rdat_reg <= bus.addr_i;
            end
          end else if (issue_mem) begin
            if (misaligned) begin
              fault_reg      <= 1'b1;
              fault_addr_reg <= bus.addr_i;
            end else begin
              state_reg    <= ST_BUS;
              count_reg    <= 8'd0;
              cyc_reg      <= 1'b1;
              we_reg       <= bus.we_i;
              sel_reg      <= sel_next;
              adr_reg      <= {bus.addr_i[63:3], 3'b000};
              wdat_reg     <= wdat_next;
              rd_lat_reg   <= bus.rd_i;
              code_lat_reg <= bus.xrs_rwe_i;
              off_lat_reg  <= bus.addr_i[2:0];
              addr_lat_reg <= bus.addr_i;
            end
          end
        end
        default: begin
          if (bus.wb_ack_i) begin
            state_reg <= ST_IDLE;
            cyc_reg   <= 1'b0;
            we_reg    <= 1'b0;
            sel_reg   <= 8'd0;
            if (!we_reg && (rd_lat_reg != 5'd0)) begin
              rwe_reg  <= 1'b1;
              rd_reg   <= rd_lat_reg;
              rdat_reg <= load_next;
            end
          end else if (timeout_hit) begin
            state_reg      <= ST_IDLE;
            cyc_reg        <= 1'b0;
            we_reg         <= 1'b0;
            sel_reg        <= 8'd0;
            fault_reg      <= 1'b1;
            fault_addr_reg <= addr_lat_reg;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
      endcase
    end
  end

  // busy depends on state alone so exec never sees a path from wb_ack_i
  assign bus.busy_o       = (state_reg == ST_BUS);
  assign bus.wb_cyc_o     = cyc_reg;
  assign bus.wb_stb_o     = cyc_reg;
  assign bus.wb_we_o      = we_reg;
  assign bus.wb_sel_o     = sel_reg;
  assign bus.wb_adr_o     = adr_reg;
  assign bus.wb_dat_o     = wdat_reg;
  assign bus.rwe_o        = rwe_reg;
  assign bus.rd_o         = rd_reg;
  assign bus.rdat_o       = rdat_reg;
  assign bus.fault_o      = fault_reg;
  assign bus.fault_addr_o = fault_addr_reg;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts every
// cycle's outputs; directed cases pin the model with literal values.
module tb_mem_stage;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int txn_no = 0;
  bit chk_en = 1'b0;
  bit chk_data = 1'b0;

  logic        exp_busy, exp_cyc, exp_we, exp_rwe, exp_fault;
  logic [7:0]  exp_sel;
  logic [4:0]  exp_rd;
  logic [63:0] exp_adr, exp_wdat, exp_rdat, exp_faddr;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] c);
    case (c)
      3'd1, 3'd5: return 1;
      3'd2, 3'd6: return 2;
      3'd3, 3'd7: return 4;
      3'd4:       return 8;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [63:0] store_rep(input logic [63:0] d, input logic [2:0] c);
    int n;
    logic [63:0] piece, r;
    n = size_bytes(c) * 8;
    if (n == 64) return d;
    piece = d & ((64'd1 << n) - 64'd1);
    r = 64'd0;
    for (int i = 0; i < 64 / n; i++) r = r | (piece << (i * n));
    return r;
  endfunction

  function automatic logic [63:0] load_val(input logic [63:0] d, input logic [2:0] off,
                                           input logic [2:0] c);
    int n;
    logic [63:0] s, mask, v;
    n = size_bytes(c) * 8;
    s = d >> (int'(off) * 8);
    if (n == 64) return s;
    mask = (64'd1 << n) - 64'd1;
    v = s & mask;
    if ((c == 3'd1 || c == 3'd2 || c == 3'd3) && v[n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] sel_of(input logic [2:0] c, input logic [2:0] off);
    logic [15:0] m;
    m = 16'((1 << size_bytes(c)) - 1) << off;
    return m[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_busy  = 1'b0;
    exp_cyc   = 1'b0;
    exp_we    = 1'b0;
    exp_sel   = 8'd0;
    exp_rwe   = 1'b0;
    exp_fault = 1'b0;
  endtask

  task automatic drive_junk();
    bus.rd_i      = 5'($urandom);
    bus.addr_i    = {$urandom, $urandom};
    bus.we_i      = 1'($urandom);
    bus.nomem_i   = 1'($urandom);
    bus.mem_i     = 1'($urandom);
    bus.dat_i     = {$urandom, $urandom};
    bus.xrs_rwe_i = 3'($urandom);
  endtask

  task automatic drive_bubble();
    bus.rd_i = 5'd0; bus.addr_i = 64'd0; bus.we_i = 1'b0; bus.nomem_i = 1'b0;
    bus.mem_i = 1'b0; bus.dat_i = 64'd0; bus.xrs_rwe_i = 3'd0;
  endtask

  // Issues one exec output; k is the BUS cycle (1-based) in which ack arrives.
  task automatic run_txn(input logic nomem, input logic mem, input logic we,
                         input logic [4:0] rd, input logic [63:0] addr,
                         input logic [63:0] dat, input logic [2:0] code,
                         input int k, input logic [63:0] rdata, output int busy_cnt);
    int bytes;
    bytes = size_bytes(code);
    busy_cnt = 0;
    txn_no++;
    $display("txn %0d nomem=%0b mem=%0b we=%0b rd=%0d addr=%h code=%0d ack_at=%0d",
             txn_no, nomem, mem, we, rd, addr, code, k);
    bus.nomem_i = nomem; bus.mem_i = mem; bus.we_i = we; bus.rd_i = rd;
    bus.addr_i = addr; bus.dat_i = dat; bus.xrs_rwe_i = code;
    tick();
    set_idle_exp();
    if (nomem) begin
      if (code != 3'd0 && rd != 5'd0) begin
        exp_rwe = 1'b1; exp_rd = rd; exp_rdat = addr;
      end
    end else if (mem && code != 3'd0) begin
      if ((addr % 64'(bytes)) != 64'd0) begin
        exp_fault = 1'b1; exp_faddr = addr;
      end else begin
        for (int j = 1; j <= 64; j++) begin
          exp_busy = 1'b1; exp_cyc = 1'b1; exp_we = we;
          exp_sel  = sel_of(code, addr[2:0]);
          exp_adr  = addr & ~64'h7;
          exp_wdat = store_rep(dat, code);
          if (bus.busy_o) busy_cnt++;
          drive_junk();
          bus.wb_ack_i = (j == k);
          bus.wb_dat_i = (j == k) ? rdata : {$urandom, $urandom};
          tick();
          bus.wb_ack_i = 1'b0;
          set_idle_exp();
          if (j == k) begin
            if (!we && rd != 5'd0) begin
              exp_rwe = 1'b1; exp_rd = rd;
              exp_rdat = load_val(rdata, addr[2:0], code);
            end
            break;
          end
          if (j == TMO) begin
            exp_fault = 1'b1; exp_faddr = addr;
            break;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 64'(bus.busy_o), 64'(exp_busy));
      cmp("cyc", 64'(bus.wb_cyc_o), 64'(exp_cyc));
      cmp("stb", 64'(bus.wb_stb_o), 64'(exp_cyc));
      cmp("we", 64'(bus.wb_we_o), 64'(exp_we));
      cmp("sel", 64'(bus.wb_sel_o), 64'(exp_sel));
      cmp("rwe", 64'(bus.rwe_o), 64'(exp_rwe));
      cmp("rd", 64'(bus.rd_o), 64'(exp_rd));
      cmp("rdat", bus.rdat_o, exp_rdat);
      cmp("fault", 64'(bus.fault_o), 64'(exp_fault));
      if (exp_fault) cmp("fault_addr", bus.fault_addr_o, exp_faddr);
      if (exp_cyc || chk_data) begin
        cmp("adr", bus.wb_adr_o, exp_adr);
        cmp("wdat", bus.wb_dat_o, exp_wdat);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    logic [2:0] code;
    logic [63:0] addr;
    int r;

    rst = 1'b1;
    drive_bubble();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 64'd0;
    set_idle_exp();
    exp_rd = 5'd0; exp_rdat = 64'd0; exp_adr = 64'd0; exp_wdat = 64'd0; exp_faddr = 64'd0;
    chk_data = 1'b1;
    chk_en = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    chk_data = 1'b0;
    tick();

    // nomem pass-through, then rd = 0 suppresses the write
    run_txn(1, 0, 0, 5'd5, 64'h1234, 64'd0, 3'd4, 1, 64'd0, bc);
    cmp("t1_rwe", 64'(bus.rwe_o), 64'd1);
    cmp("t1_rd", 64'(bus.rd_o), 64'd5);
    cmp("t1_rdat", bus.rdat_o, 64'h1234);
    cmp("t1_cyc", 64'(bus.wb_cyc_o), 64'd0);
    run_txn(1, 0, 0, 5'd0, 64'h1234, 64'd0, 3'd4, 1, 64'd0, bc);
    cmp("t1_rwe_rd0", 64'(bus.rwe_o), 64'd0);

    // S16 / U16 loads from lane 2, ack in the second BUS cycle
    run_txn(0, 1, 0, 5'd23, 64'hDFF802, 64'd0, 3'd2, 2, 64'h0000_0000_8001_0000, bc);
    cmp("t2_busy_cycles", 64'(bc), 64'd2);
    cmp("t2_rwe", 64'(bus.rwe_o), 64'd1);
    cmp("t2_rd", 64'(bus.rd_o), 64'd23);
    cmp("t2_rdat_s16", bus.rdat_o, 64'hFFFF_FFFF_FFFF_8001);
    run_txn(0, 1, 0, 5'd23, 64'hDFF802, 64'd0, 3'd6, 2, 64'h0000_0000_8001_0000, bc);
    cmp("t2_rdat_u16", bus.rdat_o, 64'h0000_0000_0000_8001);

    // S8 store to the top lane with immediate ack
    run_txn(0, 1, 1, 5'd7, 64'hE007FF, 64'hDEAD, 3'd1, 1, 64'd0, bc);
    cmp("t3_busy_cycles", 64'(bc), 64'd1);
    cmp("t3_rwe", 64'(bus.rwe_o), 64'd0);

    // misaligned S32
    run_txn(0, 1, 0, 5'd3, 64'h3FF802, 64'd0, 3'd3, 1, 64'd0, bc);
    cmp("t4_busy_cycles", 64'(bc), 64'd0);
    cmp("t4_fault", 64'(bus.fault_o), 64'd1);
    cmp("t4_fault_addr", bus.fault_addr_o, 64'h3FF802);
    cmp("t4_rwe", 64'(bus.rwe_o), 64'd0);

    // ack never comes: abort after TMO BUS cycles, then a normal ALU op
    run_txn(0, 1, 0, 5'd4, 64'h8000, 64'd0, 3'd4, 100, 64'd0, bc);
    cmp("t5_busy_cycles", 64'(bc), 64'(TMO));
    cmp("t5_fault", 64'(bus.fault_o), 64'd1);
    cmp("t5_fault_addr", bus.fault_addr_o, 64'h8000);
    cmp("t5_rwe", 64'(bus.rwe_o), 64'd0);
    run_txn(1, 0, 0, 5'd9, 64'hCAFE, 64'd0, 3'd4, 1, 64'd0, bc);
    cmp("t5_after_rdat", bus.rdat_o, 64'hCAFE);

    // asynchronous reset in the middle of a load
    txn_no++;
    $display("txn %0d reset during BUS", txn_no);
    bus.nomem_i = 1'b0; bus.mem_i = 1'b1; bus.we_i = 1'b0; bus.rd_i = 5'd12;
    bus.addr_i = 64'h1000; bus.xrs_rwe_i = 3'd4;
    tick();
    set_idle_exp();
    exp_busy = 1'b1; exp_cyc = 1'b1; exp_sel = 8'hFF; exp_adr = 64'h1000;
    exp_wdat = store_rep(bus.dat_i, 3'd4);
    drive_junk();
    tick();
    #2;
    rst = 1'b1;
    drive_bubble();
    set_idle_exp();
    exp_rd = 5'd0; exp_rdat = 64'd0; exp_adr = 64'd0; exp_wdat = 64'd0;
    chk_data = 1'b1;
    #1;
    cmp("t6_cyc_async", 64'(bus.wb_cyc_o), 64'd0);
    cmp("t6_stb_async", 64'(bus.wb_stb_o), 64'd0);
    cmp("t6_busy_async", 64'(bus.busy_o), 64'd0);
    tick();
    bus.wb_ack_i = 1'b1;
    tick();
    rst = 1'b0;
    chk_data = 1'b0;
    tick();
    bus.wb_ack_i = 1'b0;
    cmp("t6_no_rwe", 64'(bus.rwe_o), 64'd0);

    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      code = 3'($urandom);
      addr = {$urandom, $urandom};
      if (r == 0) begin
        run_txn(0, 0, 1'($urandom), 5'($urandom), addr, {$urandom, $urandom}, code, 1, 64'd0, bc);
      end else if (r <= 3) begin
        run_txn(1, 1'($urandom), 1'($urandom), 5'($urandom), addr, {$urandom, $urandom},
                code, 1, 64'd0, bc);
      end else begin
        if (code != 3'd0 && $urandom_range(0, 3) != 0)
          addr = addr & ~(64'(size_bytes(code)) - 64'd1);
        run_txn(0, 1, 1'($urandom), 5'($urandom), addr, {$urandom, $urandom}, code,
                $urandom_range(1, TMO + 1), {$urandom, $urandom}, bc);
      end
    end

    drive_bubble();
    tick(); tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
